// File: rtl/adder_share_arb_if.sv
// Bundle for adder_share_arb: requester channels, response channel, shared-adder
// connection and debug visibility of the sequencer state.
interface adder_share_arb_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not depend on ready, and operands are only looked at
  // in the cycle req_ready is high. rsp_* stay stable while rsp_valid && !rsp_ready.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sub;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_overflow;
  logic                     rsp_zero;
  logic                     rsp_exception;

  logic [WIDTH-1:0]         add_i_1;
  logic [WIDTH-1:0]         add_i_2;
  logic                     add_invert_i_2;
  logic [WIDTH-1:0]         add_o;
  logic                     add_overflow_flag;
  logic                     add_zero_flag;
  logic                     add_exception_flag;

  logic [1:0]               dbg_state;
  logic [ID_W-1:0]          dbg_last_grant;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
           add_o, add_overflow_flag, add_zero_flag, add_exception_flag,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow, rsp_zero,
           rsp_exception, add_i_1, add_i_2, add_invert_i_2,
           dbg_state, dbg_last_grant
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
           add_o, add_overflow_flag, add_zero_flag, add_exception_flag,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow, rsp_zero,
           rsp_exception, add_i_1, add_i_2, add_invert_i_2,
           dbg_state, dbg_last_grant
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer time-sharing one combinational adder between
// NUM_REQ requesters. Define ADDER_ARB_ENABLE_EN to add the add_enable output.
module adder_share_arb #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_share_arb_if.slave bus
`ifdef ADDER_ARB_ENABLE_EN
  ,
  output logic             add_enable
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_sub_q, op_sub_d;
  logic [ID_W-1:0]    op_id_q, op_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_overflow_q, rsp_overflow_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_exception_q, rsp_exception_d;

  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic               win_sub;

  // Search upward from last_grant+1 so the most recent winner has lowest priority.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_valid[i] && (ID_W'(i) == cand)) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  // Reset gates the grant so nothing is accepted while rst_n is low.
  assign accept = rst_n && found &&
                  ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

  always_comb begin
    req_ready_c = '0;
    win_a       = '0;
    win_b       = '0;
    win_sub     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        req_ready_c[i] = accept;
        win_a          = bus.req_a[i*WIDTH +: WIDTH];
        win_b          = bus.req_b[i*WIDTH +: WIDTH];
        win_sub        = bus.req_sub[i];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    op_sub_d        = op_sub_q;
    op_id_d         = op_id_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_sum_d       = rsp_sum_q;
    rsp_overflow_d  = rsp_overflow_q;
    rsp_zero_d      = rsp_zero_q;
    rsp_exception_d = rsp_exception_q;

    case (state_q)
      EXEC: begin
        rsp_valid_d     = 1'b1;
        rsp_id_d        = op_id_q;
        rsp_sum_d       = bus.add_o;
        rsp_overflow_d  = bus.add_overflow_flag;
        rsp_zero_d      = bus.add_zero_flag;
        rsp_exception_d = bus.add_exception_flag;
        state_d         = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // A new grant overrides the IDLE fallback, giving RESP->EXEC back-to-back.
    if (accept) begin
      op_a_d       = win_a;
      op_b_d       = win_b;
      op_sub_d     = win_sub;
      op_id_d      = winner;
      last_grant_d = winner;
      state_d      = EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_grant_q    <= ID_W'(NUM_REQ - 1);
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_sub_q        <= 1'b0;
      op_id_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_sum_q       <= '0;
      rsp_overflow_q  <= 1'b0;
      rsp_zero_q      <= 1'b0;
      rsp_exception_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      op_sub_q        <= op_sub_d;
      op_id_q         <= op_id_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_sum_q       <= rsp_sum_d;
      rsp_overflow_q  <= rsp_overflow_d;
      rsp_zero_q      <= rsp_zero_d;
      rsp_exception_q <= rsp_exception_d;
    end
  end

`ifdef ADDER_ARB_ENABLE_EN
  logic add_enable_q, add_enable_d;

  // High for exactly the cycles the FSM spends in EXEC.
  always_comb begin
    add_enable_d = (state_d == EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_enable_q <= 1'b0;
    end else begin
      add_enable_q <= add_enable_d;
    end
  end

  assign add_enable = add_enable_q;
`endif

  assign bus.req_ready      = req_ready_c;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_sum        = rsp_sum_q;
  assign bus.rsp_overflow   = rsp_overflow_q;
  assign bus.rsp_zero       = rsp_zero_q;
  assign bus.rsp_exception  = rsp_exception_q;
  assign bus.add_i_1        = op_a_q;
  assign bus.add_i_2        = op_b_q;
  assign bus.add_invert_i_2 = op_sub_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_last_grant = last_grant_q;

endmodule
